// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if: groups the control and handshake signals of mac_seq_ctrl.
//   start/y_ready          : requests from the surrounding system
//   busy, addr_x, addr_f   : status and memory read addresses
//   enable_mult,
//   clear_pipeline_mult    : MAC multiplier controls
//   acc_en, acc_clr        : accumulator controls
//   y_valid, done          : output handshake and completion pulse
//   stall_cnt              : back-pressure cycle counter
// master = controller side, slave = system side.
interface mac_seq_ctrl_if #(
    parameter int unsigned XW = 3,
    parameter int unsigned FW = 2
) ();
    logic          start;
    logic          busy;
    logic [XW-1:0] addr_x;
    logic [FW-1:0] addr_f;
    logic          enable_mult;
    logic          clear_pipeline_mult;
    logic          acc_en;
    logic          acc_clr;
    logic          y_valid;
    logic          y_ready;
    logic          done;
    logic [15:0]   stall_cnt;

    modport master (
        input  start, y_ready,
        output busy, addr_x, addr_f, enable_mult, clear_pipeline_mult,
               acc_en, acc_clr, y_valid, done, stall_cnt
    );

    modport slave (
        output start, y_ready,
        input  busy, addr_x, addr_f, enable_mult, clear_pipeline_mult,
               acc_en, acc_clr, y_valid, done, stall_cnt
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences a 1-D convolution y[j] = sum_k x[j+k]*f[k] on an external
// MAC unit with LAT-cycle product latency and synchronous-read x/f memories.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : mac_seq_ctrl_if.master (start, busy, addresses, MAC/accumulator controls,
//           y_valid/y_ready handshake, done pulse, stall_cnt)
// Optional feature: define MAC_SEQ_STALL_CNT_EN to count y_valid && !y_ready cycles in
// stall_cnt (saturating); otherwise stall_cnt is tied to zero.
module mac_seq_ctrl #(
    parameter int unsigned N   = 8,
    parameter int unsigned M   = 3,
    parameter int unsigned LAT = 3,
    parameter int unsigned XW  = $clog2(N),
    parameter int unsigned FW  = $clog2(M)
) (
    input logic            clk,
    input logic            reset,
    mac_seq_ctrl_if.master bus
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StIssue  = 3'd1;
    localparam logic [2:0] StDrain  = 3'd2;
    localparam logic [2:0] StOutput = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    // Tracker pattern where only the final tap sits in the last stage.
    localparam logic [LAT:0] TrkLastOnly = (LAT + 1)'(1) << LAT;

    logic [2:0]    state_q, state_d;
    logic [XW-1:0] j_q, j_d;
    logic [FW-1:0] k_q, k_d;
    logic [XW-1:0] addr_x_q, addr_x_d;
    logic [FW-1:0] addr_f_q, addr_f_d;
    // Bit 0 is stage 1 (memory data valid), bit LAT is stage 1+LAT (product at acc).
    logic [LAT:0]  trk_valid_q, trk_valid_d;
    logic [LAT:0]  trk_first_q, trk_first_d;
    logic          issue;
    logic          drain_done;

    assign issue      = (state_q == StIssue);
    assign drain_done = (trk_valid_q == TrkLastOnly);

    always_comb begin
        trk_valid_d[0] = issue;
        trk_first_d[0] = issue && (k_q == '0);
        for (int i = 1; i <= int'(LAT); i++) begin
            trk_valid_d[i] = trk_valid_q[i-1];
            trk_first_d[i] = trk_first_q[i-1];
        end
    end

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        k_d     = k_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StIssue;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            StIssue: begin
                if (k_q == FW'(M - 1)) begin
                    k_d     = '0;
                    state_d = StDrain;
                end else begin
                    k_d = k_q + FW'(1);
                end
            end
            StDrain: begin
                if (drain_done) state_d = StOutput;
            end
            StOutput: begin
                if (bus.y_ready) begin
                    if (j_q == XW'(N - M)) begin
                        state_d = StDone;
                    end else begin
                        j_d     = j_q + XW'(1);
                        state_d = StIssue;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Addresses are registered so they are presented during the ISSUE cycle itself.
    always_comb begin
        addr_x_d = addr_x_q;
        addr_f_d = addr_f_q;
        if (state_d == StIssue) begin
            addr_x_d = j_d + XW'(k_d);
            addr_f_d = k_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            j_q         <= '0;
            k_q         <= '0;
            addr_x_q    <= '0;
            addr_f_q    <= '0;
            trk_valid_q <= '0;
            trk_first_q <= '0;
        end else begin
            state_q     <= state_d;
            j_q         <= j_d;
            k_q         <= k_d;
            addr_x_q    <= addr_x_d;
            addr_f_q    <= addr_f_d;
            trk_valid_q <= trk_valid_d;
            trk_first_q <= trk_first_d;
        end
    end

    assign bus.busy        = (state_q != StIdle);
    assign bus.addr_x      = addr_x_q;
    assign bus.addr_f      = addr_f_q;
    assign bus.enable_mult = trk_valid_q[0];
    assign bus.acc_en      = trk_valid_q[LAT];
    assign bus.acc_clr     = trk_valid_q[LAT] && trk_first_q[LAT];
    assign bus.y_valid     = (state_q == StOutput);
    assign bus.done        = (state_q == StDone);
    // Combinational on start; gated so reset forces it low in the same cycle.
    assign bus.clear_pipeline_mult = (state_q == StIdle) && bus.start && !reset;

`ifdef MAC_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == StIdle) && bus.start) begin
            stall_cnt_d = '0;
        end else if ((state_q == StOutput) && !bus.y_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: drives mac_seq_ctrl with random memory contents and y_ready patterns,
// models the x/f memories, a LAT-stage multiplier and an accumulator around it, and checks
// every accepted y against sum_k x[j+k]*f[k] held in a scoreboard queue.
module tb_mac_seq_ctrl;
    localparam int unsigned N      = 8;
    localparam int unsigned M      = 3;
    localparam int unsigned LAT    = 3;
    localparam int unsigned XW     = $clog2(N);
    localparam int unsigned FW     = $clog2(M);
    localparam int unsigned NOUT   = N - M + 1;
    localparam int unsigned PERIOD = M + LAT + 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_seq_ctrl_if #(.XW(XW), .FW(FW)) bus ();

    mac_seq_ctrl #(.N(N), .M(M), .LAT(LAT), .XW(XW), .FW(FW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Environment: sync-read memories, product pipeline, accumulator.
    logic [7:0]  xmem [N];
    logic [7:0]  fmem [M];
    logic [7:0]  x_rd, f_rd;
    logic [15:0] prod_p [LAT];
    logic [31:0] acc;

    always @(posedge clk) begin
        x_rd <= xmem[bus.addr_x];
        f_rd <= (int'(bus.addr_f) < M) ? fmem[bus.addr_f] : 8'd0;
        if (bus.clear_pipeline_mult) begin
            for (int i = 0; i < int'(LAT); i++) prod_p[i] <= 16'd0;
        end else begin
            prod_p[0] <= bus.enable_mult ? 16'(x_rd) * 16'(f_rd) : 16'd0;
            for (int i = 1; i < int'(LAT); i++) prod_p[i] <= prod_p[i-1];
        end
        if (bus.acc_en) acc <= bus.acc_clr ? 32'(prod_p[LAT-1]) : acc + 32'(prod_p[LAT-1]);
    end

    // Scoreboard and monitor.
    longint exp_q [$];
    int     hs_q [$];
    int     cyc = 0;
    int     done_count = 0;
    int     clr_count = 0;
    int     stall_seen = 0;
    int     last_hs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.clear_pipeline_mult) clr_count++;
            if (bus.y_valid) begin
                check("no_enable_mult_during_output", bus.enable_mult, 0);
                if (!bus.y_ready) begin
                    stall_seen++;
                end else begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL y_unexpected: got y=%0d with no expected value queued", acc);
                    end else begin
                        check("y_value", acc, exp_q.pop_front());
                    end
                    hs_q.push_back(cyc);
                    last_hs = cyc;
                end
            end
            if (bus.done) begin
                done_count++;
                check("done_one_cycle_after_last_hs", cyc - last_hs, 1);
                check("scoreboard_empty_at_done", exp_q.size(), 0);
            end
        end
    end

    task automatic load_data(input bit fixed);
        for (int i = 0; i < int'(N); i++) xmem[i] = fixed ? 8'(i + 1) : 8'($urandom_range(0, 255));
        for (int k = 0; k < int'(M); k++) fmem[k] = fixed ? 8'd1 : 8'($urandom_range(0, 255));
    endtask

    // Reference: direct convolution of the current memory contents.
    task automatic push_expected();
        for (int j = 0; j < int'(NOUT); j++) begin
            longint s = 0;
            for (int k = 0; k < int'(M); k++) s += longint'(xmem[j+k]) * longint'(fmem[k]);
            exp_q.push_back(s);
        end
    endtask

    task automatic start_run();
        hs_q.delete();
        stall_seen = 0;
        clr_count  = 0;
        @(posedge clk); #1;
        check("idle_before_start", bus.busy, 0);
        bus.start = 1'b1;
    endtask

    // mode 0: y_ready high; 1: random y_ready; 2: 5-cycle stall on y[2]; 3: start held high
    task automatic run(input int mode, input bit fixed);
        int base_done = done_count;
        int budget = 0;
        int stalled = 0;
        longint stall_exp;
        load_data(fixed);
        push_expected();
        start_run();
        @(posedge clk); #1;
        bus.start = (mode == 3);
        while (done_count == base_done && budget < 2000) begin
            case (mode)
                1: bus.y_ready = 1'($urandom_range(0, 1));
                2: begin
                    bus.y_ready = !(bus.y_valid && hs_q.size() == 2 && stalled < 5);
                    if (!bus.y_ready) stalled++;
                end
                default: bus.y_ready = 1'b1;
            endcase
            @(posedge clk); #1;
            budget++;
        end
        bus.start   = 1'b0;
        bus.y_ready = 1'b1;
        if (done_count == base_done) begin
            checks++;
            $display("FAIL run_timeout: mode %0d got no done within %0d cycles", mode, budget);
        end
        repeat (2 * PERIOD) @(posedge clk);
        #1;
        check("done_pulses", done_count - base_done, 1);
        check("idle_after_run", bus.busy, 0);
        check("handshake_count", hs_q.size(), NOUT);
        check("clear_pipeline_pulses", clr_count, 1);
        if (mode != 1) begin
            for (int i = 1; i < hs_q.size(); i++)
                check("handshake_spacing", hs_q[i] - hs_q[i-1],
                      PERIOD + ((mode == 2 && i == 2) ? 5 : 0));
        end
`ifdef MAC_SEQ_STALL_CNT_EN
        stall_exp = (mode == 1) ? longint'(stall_seen) : (mode == 2) ? 5 : 0;
`else
        stall_exp = 0;
`endif
        check("stall_cnt", bus.stall_cnt, stall_exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_addr_x"}, bus.addr_x, 0);
        check({tag, "_addr_f"}, bus.addr_f, 0);
        check({tag, "_enable_mult"}, bus.enable_mult, 0);
        check({tag, "_clear_pipeline_mult"}, bus.clear_pipeline_mult, 0);
        check({tag, "_acc_en"}, bus.acc_en, 0);
        check({tag, "_acc_clr"}, bus.acc_clr, 0);
        check({tag, "_y_valid"}, bus.y_valid, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_stall_cnt"}, bus.stall_cnt, 0);
    endtask

    task automatic reset_in_drain();
        int budget = 0;
        load_data(1'b0);
        push_expected();
        start_run();
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.y_ready = 1'b1;
        while ((hs_q.size() < 3 || !bus.enable_mult) && budget < 500) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 500) begin
            checks++;
            $display("FAIL drain_wait_timeout: got %0d handshakes, needed 3", hs_q.size());
        end
        // First enable_mult of y[3]; two more edges land in DRAIN.
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_busy", bus.busy, 1);
        check("pre_reset_y_valid", bus.y_valid, 0);
        reset = 1'b1;
        #1;
        check_all_zero("reset_in_drain");
        exp_q.delete();
        @(posedge clk); #1;
        check_all_zero("reset_held");
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("no_activity_after_reset", bus.busy, 0);
    endtask

    initial begin
        reset       = 1'b1;
        bus.start   = 1'b1;
        bus.y_ready = 1'b0;
        for (int i = 0; i < int'(LAT); i++) prod_p[i] = 16'd0;
        acc = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        bus.start = 1'b0;
        reset     = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("idle_after_reset_release", bus.busy, 0);

        run(0, 1'b1);
        run(0, 1'b0);
        run(2, 1'b0);
        run(1, 1'b0);
        run(3, 1'b0);
        reset_in_drain();
        run(0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 Parameters (name, default, meaning): N 8, input vector length; M 3, filter taps; LAT 3, MAC latency from enable_mult to product at accumulator input; XW $clog2(N), x address width; FW $clog2(M), f address width.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin one convolution; sampled in IDLE only.
REQ-005 busy  output  1  high in every state except IDLE.
REQ-006 addr_x  output  XW  registered x-memory read address (1-cycle synchronous read).
REQ-007 addr_f  output  FW  registered f-memory read address.
REQ-008 enable_mult  output  1  MAC multiplier enable; high in the cycle memory data is valid.
REQ-009 clear_pipeline_mult  output  1  one-cycle flush of MAC multiplier pipeline.
REQ-010 acc_en  output  1  accumulator adds current product.
REQ-011 acc_clr  output  1  accumulator loads current product instead of adding (first tap).
REQ-012 y_valid  output  1  accumulated output y[j] is valid.
REQ-013 y_ready  input  1  consumer accepts y[j] when y_valid&&y_ready.
REQ-014 done  output  1  one-cycle pulse after final handshake.
REQ-015 stall_cnt  output  16  count of y_valid&&!y_ready cycles (see Configuration).

Function
REQ-016 States: IDLE, ISSUE, DRAIN, OUTPUT, DONE.
REQ-017 IDLE->ISSUE on start=1; clear_pipeline_mult=1 in that transition cycle only; j=0, k=0.
REQ-018 ISSUE: each cycle drive addr_x=j+k, addr_f=k, set tracker bit; k increments; after k=M-1 go to DRAIN, k=0.
REQ-019 Tracker: shift register of depth 1+LAT carrying {valid, first}; enable_mult = stage-1 valid; acc_en = stage-(1+LAT) valid; acc_clr = acc_en && first; first set only for k=0.
REQ-020 DRAIN: remain until tracker empty and the last acc_en has been issued, i.e. exactly 1+LAT cycles after last ISSUE cycle; then OUTPUT.
REQ-021 OUTPUT: y_valid=1; hold y_valid and all other outputs stable until y_ready=1.
REQ-022 On handshake: if j==N-M go to DONE, else j++ and go to ISSUE (no clear_pipeline_mult).
REQ-023 DONE: done=1 for one cycle, then IDLE.
REQ-024 Latency per output with y_ready held high: M+LAT+2 cycles (ISSUE M, DRAIN 1+LAT, OUTPUT 1); total outputs N-M+1.
REQ-025 start while busy is ignored; y_ready outside OUTPUT is ignored.
REQ-026 Outputs never overlap: ISSUE for y[j+1] never begins before handshake of y[j].
REQ-027 addr_x never exceeds N-1; M>N is an illegal parameterization, not required to function.

Reset
REQ-028 reset=1 immediately forces IDLE, clears j, k, tracker, stall_cnt; all outputs 0, including mid-ISSUE, DRAIN or OUTPUT.
REQ-029 After reset deassertion nothing happens until a new start.

Configuration
REQ-030 Macro MAC_SEQ_STALL_CNT_EN: defined -> stall_cnt increments (saturating at 16'hFFFF) each cycle y_valid&&!y_ready, cleared on start acceptance and reset.
REQ-031 Undefined -> stall_cnt tied to 0, counter logic absent; all other behaviour identical.

Verification
REQ-032 N=8,M=3, start pulse, y_ready=1 -> addr_x sequences 0,1,2 / 1,2,3 / ... / 5,6,7; 6 y_valid pulses each 8 cycles apart; done 1 cycle after 6th handshake.
REQ-033 Same config, data x=1..8, f={1,1,1} with real MAC+accumulator -> y = 6,9,12,15,18,21.
REQ-034 y_ready low 5 cycles on y[2] -> y_valid held 6 cycles, no new enable_mult meanwhile; stall_cnt=5 with macro, 0 without.
REQ-035 reset asserted during DRAIN of y[3] -> all outputs 0 same cycle, busy=0; new start re-runs from y[0] with clear_pipeline_mult pulse.
REQ-036 start held high during run and pulsed during OUTPUT -> no restart, sequence identical to REQ-032, exactly one done pulse.
